stream_mux_rr: RTL and testbench

- Parametrised N:1 registered stream multiplexer; next generation of the 4:1 single-bit structural mux.
- Generalises channel count and data width.
- Adds a valid/ready handshake on every input and on the output, a one-entry output register, and two selection modes: addressed (external select, as before) and round-robin fair arbitration.
- Sits between multiple producer channels and one shared consumer in the datapath.

---
 rtl/mux_pkg.sv | 14 +
 rtl/rr_pick.sv | 30 +++
 rtl/stream_mux_rr.sv | 122 ++++++++++++
 tb/tb_stream_mux_rr.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the round-robin stream multiplexer.
package mux_pkg;

    localparam logic MODE_ADDR = 1'b0;
    localparam logic MODE_RR   = 1'b1;

    // Wrap an index into [0, channels). Callers only ever pass idx < 2*channels
    // (pointer plus offset), so one conditional subtract replaces a modulo.
    function automatic int unsigned wrap_idx(input int unsigned idx,
                                             input int unsigned channels);
        return (idx >= channels) ? (idx - channels) : idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first requesting channel at or after ptr, wrapping around.
module rr_pick
    import mux_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SELW     = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SELW-1:0]     ptr,
    output logic [SELW-1:0]     grant,
    output logic                any_req
);

    logic [SELW-1:0] idx;

    // Scan ptr, ptr+1, ... wrapping; the first hit wins.
    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        idx     = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            idx = SELW'(wrap_idx(32'(ptr) + i, CHANNELS));
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                grant   = idx;
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N:1 registered stream multiplexer with addressed and round-robin selection.
module stream_mux_rr
    import mux_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH    = 1,
    parameter int unsigned SELW     = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mode,
    input  logic [SELW-1:0]           addr,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SELW-1:0]           out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam logic [SELW:0]   NCH  = (SELW + 1)'(CHANNELS);
    localparam logic [SELW-1:0] LAST = SELW'(CHANNELS - 1);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_chan_q, out_chan_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  ptr_q, ptr_d;
    // Low during reset and for the first cycle after release, so no handshake
    // can complete while the output register is being cleared.
    logic             en_q;

    logic [SELW-1:0]  rr_grant;
    logic             rr_any;
    logic [SELW-1:0]  grant;
    logic             grant_ok;
    logic             space;
    logic             sel_valid;
    logic [WIDTH-1:0] sel_data;
    logic             xfer;

    rr_pick #(
        .CHANNELS (CHANNELS),
        .SELW     (SELW)
    ) u_rr_pick (
        .req     (in_valid),
        .ptr     (ptr_q),
        .grant   (rr_grant),
        .any_req (rr_any)
    );

    assign space = !out_valid_q || out_ready;

    // Choose the granted channel from the active selection mode.
    always_comb begin
        grant    = '0;
        grant_ok = 1'b0;
        if (mode == MODE_RR) begin
            grant    = rr_grant;
            grant_ok = rr_any;
        end else begin
            grant    = addr;
            grant_ok = ({1'b0, addr} < NCH);
        end
    end

    // Steer ready to the granted channel and mux its valid/data.
    always_comb begin
        in_ready  = '0;
        sel_valid = 1'b0;
        sel_data  = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (grant_ok && (grant == SELW'(k))) begin
                in_ready[k] = space && en_q;
                sel_valid   = in_valid[k];
                sel_data    = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign xfer = sel_valid && space && en_q;

    // Next state of the output register and the round-robin pointer.
    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            out_data_d  = sel_data;
            out_chan_d  = grant;
            out_valid_d = 1'b1;
            if (mode == MODE_RR) begin
                ptr_d = (grant == LAST) ? '0 : grant + SELW'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
            en_q        <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
            en_q        <= 1'b1;
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: a 4-channel and a 3-channel instance, vector tables
// for the ready pattern, and a queue scoreboard for the output beats.
module tb_stream_mux_rr;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 4-channel instance
    logic        mode4;
    logic [1:0]  addr4;
    logic [31:0] data4;
    logic [3:0]  valid4, ready4;
    logic [7:0]  odata4;
    logic [1:0]  ochan4;
    logic        ovalid4, oready4;

    // 3-channel instance
    logic        mode3;
    logic [1:0]  addr3;
    logic [23:0] data3;
    logic [2:0]  valid3, ready3;
    logic [7:0]  odata3;
    logic [1:0]  ochan3;
    logic        ovalid3, oready3;

    stream_mux_rr #(.CHANNELS(4), .WIDTH(8)) dut4 (
        .clk (clk), .rst_n (rst_n), .mode (mode4), .addr (addr4),
        .in_data (data4), .in_valid (valid4), .in_ready (ready4),
        .out_data (odata4), .out_chan (ochan4), .out_valid (ovalid4),
        .out_ready (oready4)
    );

    stream_mux_rr #(.CHANNELS(3), .WIDTH(8)) dut3 (
        .clk (clk), .rst_n (rst_n), .mode (mode3), .addr (addr3),
        .in_data (data3), .in_valid (valid3), .in_ready (ready3),
        .out_data (odata3), .out_chan (ochan3), .out_valid (ovalid3),
        .out_ready (oready3)
    );

    typedef struct packed {
        logic       mode;
        logic [1:0] addr;
        logic [3:0] valid;
        logic       oready;
        logic [3:0] exp_ready;
    } vec_t;

    vec_t t4 [22];
    vec_t t3 [7];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic       m_en, mv4, mv3;
    int         ptr4, ptr3;
    logic [9:0] q4 [$];
    logic [9:0] q3 [$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model(input int n, input logic mode, input logic [1:0] addr,
                                  input logic [3:0] v, input logic ordy, input logic en,
                                  input logic mv, input int ptr,
                                  output logic [3:0] rdy, output logic x, output int g);
        logic space;
        space = !mv || ordy;
        g = -1;
        if (!mode) begin
            if (int'(addr) < n) g = int'(addr);
        end else begin
            for (int i = 0; i < n; i++) begin
                int k;
                k = (ptr + i) % n;
                if (g < 0 && v[k]) g = k;
            end
        end
        rdy = '0;
        x   = 1'b0;
        if (g >= 0 && en && space) begin
            rdy[g] = 1'b1;
            x      = v[g];
        end
    endfunction

    // Check one cycle against the model, then advance across the next edge.
    task automatic step();
        logic [3:0] r;
        logic       x;
        int         g;
        logic [9:0] e;
        #1;
        model(4, mode4, addr4, valid4, oready4, m_en, mv4, ptr4, r, x, g);
        check("ready4_model", 32'(ready4), 32'(r));
        check("ovalid4_model", 32'(ovalid4), 32'(mv4));
        if (ovalid4 && oready4) begin
            if (q4.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL out4_beat: got %0h, expected no beat", {ochan4, odata4});
            end else begin
                e = q4.pop_front();
                check("out4_beat", 32'({ochan4, odata4}), 32'(e));
            end
        end
        if (x) begin
            q4.push_back({g[1:0], data4[g*8 +: 8]});
            if (mode4) ptr4 = (g + 1) % 4;
        end
        mv4 = x ? 1'b1 : (oready4 ? 1'b0 : mv4);

        model(3, mode3, addr3, {1'b0, valid3}, oready3, m_en, mv3, ptr3, r, x, g);
        check("ready3_model", 32'(ready3), 32'(r[2:0]));
        check("ovalid3_model", 32'(ovalid3), 32'(mv3));
        if (ovalid3 && oready3) begin
            if (q3.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL out3_beat: got %0h, expected no beat", {ochan3, odata3});
            end else begin
                e = q3.pop_front();
                check("out3_beat", 32'({ochan3, odata3}), 32'(e));
            end
        end
        if (x) begin
            q3.push_back({g[1:0], data3[g*8 +: 8]});
            if (mode3) ptr3 = (g + 1) % 3;
        end
        mv3 = x ? 1'b1 : (oready3 ? 1'b0 : mv3);

        m_en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // mode, addr, valid, out_ready, expected in_ready
        t4[0]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0000};
        t4[1]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100};
        t4[2]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100};
        t4[3]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100};
        t4[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001};
        t4[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010};
        t4[6]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100};
        t4[7]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000};
        t4[8]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001};
        t4[9]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010};
        t4[10] = '{1'b1, 2'd0, 4'b1000, 1'b1, 4'b1000};
        t4[11] = '{1'b1, 2'd0, 4'b1000, 1'b1, 4'b1000};
        t4[12] = '{1'b1, 2'd0, 4'b1000, 1'b1, 4'b1000};
        t4[13] = '{1'b1, 2'd0, 4'b0000, 1'b0, 4'b0000};
        t4[14] = '{1'b1, 2'd0, 4'b0010, 1'b0, 4'b0000};
        t4[15] = '{1'b1, 2'd0, 4'b0010, 1'b0, 4'b0000};
        t4[16] = '{1'b1, 2'd0, 4'b0010, 1'b1, 4'b0010};
        t4[17] = '{1'b1, 2'd0, 4'b0001, 1'b1, 4'b0001};
        t4[18] = '{1'b0, 2'd0, 4'b1111, 1'b1, 4'b0001};
        t4[19] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010};
        t4[20] = '{1'b0, 2'd3, 4'b0000, 1'b1, 4'b1000};
        t4[21] = '{1'b0, 2'd3, 4'b0000, 1'b1, 4'b1000};

        t3[0] = '{1'b1, 2'd0, 4'b0010, 1'b1, 4'b0010};
        t3[1] = '{1'b0, 2'd3, 4'b0111, 1'b1, 4'b0000};
        t3[2] = '{1'b0, 2'd3, 4'b0111, 1'b1, 4'b0000};
        t3[3] = '{1'b1, 2'd0, 4'b0111, 1'b1, 4'b0100};
        t3[4] = '{1'b1, 2'd0, 4'b0111, 1'b1, 4'b0001};
        t3[5] = '{1'b1, 2'd0, 4'b0111, 1'b1, 4'b0010};
        t3[6] = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000};

        data4 = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        data3 = {8'h32, 8'h21, 8'h10};
        mode3 = 1'b0; addr3 = 2'd0; valid3 = 3'b000; oready3 = 1'b1;
        mode4 = 1'b0; addr4 = 2'd2; valid4 = 4'b1111; oready4 = 1'b1;
        m_en = 1'b0; mv4 = 1'b0; mv3 = 1'b0; ptr4 = 0; ptr3 = 0;

        // Reset held with all inputs active
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ovalid", 32'(ovalid4), 32'd0);
        check("rst_odata", 32'(odata4), 32'h00);
        check("rst_ochan", 32'(ochan4), 32'd0);
        check("rst_ready", 32'(ready4), 32'd0);
        rst_n = 1'b1;

        // 4-channel vector table
        for (int i = 0; i < 22; i++) begin
            mode4   = t4[i].mode;
            addr4   = t4[i].addr;
            valid4  = t4[i].valid;
            oready4 = t4[i].oready;
            #1;
            check($sformatf("t4[%0d].ready", i), 32'(ready4), 32'(t4[i].exp_ready));
            if (i >= 13 && i <= 15) begin
                check($sformatf("t4[%0d].hold_data", i), 32'(odata4), 32'hD3);
                check($sformatf("t4[%0d].hold_chan", i), 32'(ochan4), 32'd3);
            end
            step();
        end
        // Drained with no refill: data and channel keep the last beat
        check("drain_ovalid", 32'(ovalid4), 32'd0);
        check("drain_odata", 32'(odata4), 32'hB1);
        check("drain_ochan", 32'(ochan4), 32'd1);

        // 3-channel vector table
        mode4 = 1'b0; addr4 = 2'd0; valid4 = 4'b0000; oready4 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            mode3   = t3[i].mode;
            addr3   = t3[i].addr;
            valid3  = t3[i].valid[2:0];
            oready3 = t3[i].oready;
            #1;
            check($sformatf("t3[%0d].ready", i), 32'(ready3), 32'(t3[i].exp_ready[2:0]));
            step();
        end

        // Asynchronous reset while a beat is held
        mode4 = 1'b0; addr4 = 2'd1; valid4 = 4'b0010; oready4 = 1'b1;
        step();
        valid4 = 4'b0000; oready4 = 1'b0;
        #1;
        check("mid_held_valid", 32'(ovalid4), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ovalid", 32'(ovalid4), 32'd0);
        check("mid_rst_odata", 32'(odata4), 32'h00);
        check("mid_rst_ready", 32'(ready4), 32'd0);
        mv4 = 1'b0; mv3 = 1'b0; ptr4 = 0; ptr3 = 0; m_en = 1'b0;
        q4.delete();
        q3.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        oready4 = 1'b1; valid4 = 4'b0010;
        step();
        step();
        valid4 = 4'b0000;
        step();
        step();

        check("q4_empty", 32'(q4.size()), 32'd0);
        check("q3_empty", 32'(q3.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
